// File: rtl/alu_share_arb.sv
// Shares one combinational integer ALU between the execute stage (port 0) and the
// address/branch helper (port 1). Results land in a one-entry response slot tagged with the requester.
module alu_share_arb #(
   parameter int XLEN       = 32,
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            req0_valid,
   output logic            req0_ready,
   input  logic [XLEN-1:0] req0_rs1,
   input  logic [XLEN-1:0] req0_rs2,
   input  logic            req0_sub,
   input  logic [2:0]      req0_func3,
   input  logic            req1_valid,
   output logic            req1_ready,
   input  logic [XLEN-1:0] req1_rs1,
   input  logic [XLEN-1:0] req1_rs2,
   input  logic            req1_sub,
   input  logic [2:0]      req1_func3,
   output logic [XLEN-1:0] alu_rs1,
   output logic [XLEN-1:0] alu_rs2,
   output logic            alu_sub,
   output logic [2:0]      alu_func3,
   input  logic [XLEN-1:0] alu_result,
   input  logic [2:0]      alu_compare,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic            rsp_id,
   output logic [XLEN-1:0] rsp_result,
   output logic [2:0]      rsp_compare
);

   logic            rsp_valid_q, rsp_valid_d;
   logic            rsp_id_q, rsp_id_d;
   logic [XLEN-1:0] rsp_result_q, rsp_result_d;
   logic [2:0]      rsp_compare_q, rsp_compare_d;
   logic            rr_ptr_q, rr_ptr_d;

   logic            can_issue;
   logic            grant_id;
   logic            accept;

   // The slot may take a new op when empty or being drained this same cycle.
   assign can_issue = resetn && (!rsp_valid_q || rsp_ready);

   always_comb begin
      grant_id = 1'b0;
      if (req0_valid && req1_valid) begin
         grant_id = FIXED_PRIO ? 1'b0 : rr_ptr_q;
      end else if (req1_valid) begin
         grant_id = 1'b1;
      end
   end

   assign req0_ready = can_issue && req0_valid && !grant_id;
   assign req1_ready = can_issue && req1_valid && grant_id;
   assign accept     = req0_ready || req1_ready;

   // With nothing valid grant_id is 0, so the ALU sees steady port 0 inputs.
   assign alu_rs1   = grant_id ? req1_rs1   : req0_rs1;
   assign alu_rs2   = grant_id ? req1_rs2   : req0_rs2;
   assign alu_sub   = grant_id ? req1_sub   : req0_sub;
   assign alu_func3 = grant_id ? req1_func3 : req0_func3;

   always_comb begin
      rsp_valid_d   = rsp_valid_q;
      rsp_id_d      = rsp_id_q;
      rsp_result_d  = rsp_result_q;
      rsp_compare_d = rsp_compare_q;
      rr_ptr_d      = rr_ptr_q;
      if (accept) begin
         rsp_valid_d   = 1'b1;
         rsp_id_d      = grant_id;
         rsp_result_d  = alu_result;
         rsp_compare_d = alu_compare;
         if (!FIXED_PRIO) begin
            rr_ptr_d = ~grant_id;
         end
      end else if (rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         rsp_valid_q   <= 1'b0;
         rsp_id_q      <= 1'b0;
         rsp_result_q  <= '0;
         rsp_compare_q <= '0;
         rr_ptr_q      <= 1'b0;
      end else begin
         rsp_valid_q   <= rsp_valid_d;
         rsp_id_q      <= rsp_id_d;
         rsp_result_q  <= rsp_result_d;
         rsp_compare_q <= rsp_compare_d;
         rr_ptr_q      <= rr_ptr_d;
      end
   end

   assign rsp_valid   = rsp_valid_q;
   assign rsp_id      = rsp_id_q;
   assign rsp_result  = rsp_result_q;
   assign rsp_compare = rsp_compare_q;

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Shares the single-cycle integer ALU between two requesters: port 0 is the execute stage and port 1 is the address/branch helper.
- Arbitrates one operation per cycle and drives the ALU operand/control inputs from the granted request.
- Captures the ALU result and compare flags into a one-entry registered response slot, tagged with the requester id.
- Sits between the decode/execute logic and the ALU instance; the ALU itself stays purely combinational.

Parameters:
- XLEN, 32, operand/result width.
- FIXED_PRIO, 0, 0 = round-robin between ports; 1 = port 0 always wins.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  synchronous reset, active-low.
- req0_valid  in  1  port 0 has an operation.
- req0_ready  out  1  port 0 operation accepted this cycle.
- req0_rs1, req0_rs2  in  XLEN  port 0 operands.
- req0_sub  in  1  port 0 subtract/arith-shift select.
- req0_func3  in  3  port 0 RV32I func3.
- req1_valid, req1_ready, req1_rs1, req1_rs2, req1_sub, req1_func3  same as port 0, for port 1.
- alu_rs1, alu_rs2  out  XLEN  to ALU operands.
- alu_sub  out  1  to ALU sub.
- alu_func3  out  3  to ALU func3.
- alu_result  in  XLEN  from ALU result.
- alu_compare  in  3  from ALU compare flags.
- rsp_valid  out  1  response slot holds a result.
- rsp_ready  in  1  consumer takes the response.
- rsp_id  out  1  requester that issued the response.
- rsp_result  out  XLEN  captured result.
- rsp_compare  out  3  captured compare flags.

Behaviour:
- Reset (resetn low at a clk edge): rsp_valid=0, rsp_id=0, rsp_result=0, rsp_compare=0, rr_ptr=0 (port 0 holds priority).
- Reset is synchronous and overrides every other event in that cycle. A response pending at reset is discarded, and requests presented in that cycle are not accepted (req*_ready=0 while resetn=0).
- can_issue = resetn && (!rsp_valid || rsp_ready). This is the only back-pressure source.
- Grant is combinational:
  - If only one port is valid, it wins.
  - If both are valid: port rr_ptr wins when FIXED_PRIO=0; port 0 wins when FIXED_PRIO=1.
  - reqN_ready = can_issue && grant==N. At most one ready is high per cycle.
- ALU drive is combinational from the granted port.
  - With no valid request, the ALU drive holds the port 0 inputs. This is don't-care, but stable values are required so the ALU does not toggle.
- Acceptance: reqN_valid && reqN_ready at edge N.
  - At edge N: rsp_result<=alu_result, rsp_compare<=alu_compare, rsp_id<=N, rsp_valid<=1.
  - Latency is exactly 1 cycle from accept to rsp_valid.
- Response hold: rsp_valid && !rsp_ready holds rsp_* stable and keeps both req*_ready low.
- Simultaneous drain and fill: rsp_ready high plus a new accept in the same cycle makes the slot reload with no bubble. Full throughput is 1 op/cycle.
- Drain only: rsp_ready high with no accept sets rsp_valid<=0; rsp_result/rsp_compare keep their last value.
- Round-robin pointer: updated only on an accepted grant, rr_ptr <= ~granted_id. It is not updated when FIXED_PRIO=1, and not updated on stall cycles. A port stalled by back-pressure therefore keeps its priority.
- Width rules:
  - Operands and result pass through unmodified, with no sign or zero extension inside this block.
  - The shift amount is truncated by the ALU; this block does not mask it.
- Requesters must hold their inputs stable while valid && !ready; the arbiter does not latch unaccepted requests.
- No combinational path exists from rsp_ready to rsp_*. The path rsp_ready -> req*_ready is combinational and permitted.

Test Plan:
- Reset, then port 0 only: rs1=5, rs2=7, func3=0, sub=0, rsp_ready=1 -> req0_ready=1 in cycle 0; next cycle rsp_valid=1, rsp_id=0, rsp_result=0x0000000C.
- Subtract on port 1 only: rs1=5, rs2=7, func3=0, sub=1 -> rsp_result=0xFFFFFFFE, rsp_id=1.
- Both ports valid for 4 cycles, rsp_ready=1, FIXED_PRIO=0 -> grants alternate 0,1,0,1. With FIXED_PRIO=1 -> grants are 0,0,0,0 and req1_ready never rises.
- Back-pressure: accept port 0 (func3=7, 0xF0F0F0F0 & 0x0FF00FF0 = 0x00F000F0), then hold rsp_ready=0 for 3 cycles with both ports valid -> rsp_* stable at 0x00F000F0, both readys low, rr_ptr unchanged. Releasing rsp_ready grants port 1 in that same cycle.
- Back-to-back: port 1 streams func3=1, rs1=1, rs2=0..3, rsp_ready=1 -> one response per cycle with results 1, 2, 4, 8 and no bubble.
- Reset mid-operation: rsp_valid=1 pending, drive resetn=0 for one edge with req0_valid=1 -> after the edge rsp_valid=0, rsp_result=0, rr_ptr=0, and no accept occurs in the reset cycle.
